// File: rtl/bk_audio_mixer.sv
// bk_audio_mixer: BK0011M speaker/tape + YM2149 mix with PSG-mode hold timer and one-pole low-pass per side
//   clk_sys, reset (async, active-high), ce (sample enable, one clk_sys wide)
//   spk[2:0] speaker/tape level, ch_a/ch_b/ch_c[7:0] PSG channels, psg_active[5:0] PSG activity
//   audio_l/audio_r[15:0] unsigned samples (low 6 bits zero), psg_mode gain mode (1 = PSG+speaker)
module bk_audio_mixer #(
  parameter int FILTER_SHIFT = 3,
  parameter int HOLD_BITS = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce,
  input  logic [2:0]           spk,
  input  logic [7:0]           ch_a,
  input  logic [7:0]           ch_b,
  input  logic [7:0]           ch_c,
  input  logic [5:0]           psg_active,
  output logic [15:0]          audio_l,
  output logic [15:0]          audio_r,
  output logic                 psg_mode
);
  localparam int AW = 10 + FILTER_SHIFT;
  logic [HOLD_BITS-1:0] hold;
  logic [AW-1:0] acc_l, acc_r;
  logic [9:0] x_l, x_r, psg_l, psg_r;
  assign psg_l = {1'b0, ch_a, 1'b0} + {2'b0, ch_b} + {2'b0, spk, 5'b0};
  assign psg_r = {1'b0, ch_c, 1'b0} + {2'b0, ch_b} + {2'b0, spk, 5'b0};
  // psg_mode here is the pre-update value, so a mode change lands on the following ce
  assign x_l = psg_mode ? psg_l : {spk, 7'b0};
  assign x_r = psg_mode ? psg_r : {spk, 7'b0};
  assign audio_l = {acc_l[AW-1:FILTER_SHIFT], 6'd0};
  assign audio_r = {acc_r[AW-1:FILTER_SHIFT], 6'd0};
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold     <= '0;
      psg_mode <= 1'b0;
      acc_l    <= '0;
      acc_r    <= '0;
    end else if (ce) begin
      if (psg_active != 6'd0) begin
        psg_mode <= 1'b1;
        hold     <= '1;
      end else if (psg_mode && hold != '0) begin
        hold <= hold - 1'b1;
      end else if (psg_mode) begin
        psg_mode <= 1'b0;
      end
      // true result is non-negative and below 2^AW, so modular AW-bit arithmetic is exact;
      // with FILTER_SHIFT = 0 this collapses to acc <= x
      acc_l <= acc_l + AW'(x_l) - (acc_l >> FILTER_SHIFT);
      acc_r <= acc_r + AW'(x_r) - (acc_r >> FILTER_SHIFT);
    end
  end
endmodule

// File: tb/tb_bk_audio_mixer.sv
// tb_bk_audio_mixer: directed + random checks of bk_audio_mixer against an arithmetic reference model
module tb_bk_audio_mixer;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic ce = 1'b0;
  logic [2:0] spk = '0;
  logic [7:0] ch_a = '0, ch_b = '0, ch_c = '0;
  logic [5:0] psg_active = '0;
  logic [15:0] fl, fr, pl, pr;
  logic fm, pm;
  int npass = 0, nfail = 0;
  int tick_n = 0, last_act = -1;
  int fa_l = 0, fa_r = 0, px_l = 0, px_r = 0;

  always #5 clk_sys = ~clk_sys;

  bk_audio_mixer #(.FILTER_SHIFT(3), .HOLD_BITS(4)) dut_f (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .spk(spk), .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c),
    .psg_active(psg_active), .audio_l(fl), .audio_r(fr), .psg_mode(fm));
  bk_audio_mixer #(.FILTER_SHIFT(0), .HOLD_BITS(4)) dut_p (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .spk(spk), .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c),
    .psg_active(psg_active), .audio_l(pl), .audio_r(pr), .psg_mode(pm));

  // PSG mode is on iff some active tick lies within the last 16 ticks (hold of 2^4)
  function automatic bit mode_now();
    return last_act >= 0 && (tick_n - 1 - last_act) < 16;
  endfunction

  task automatic model_reset();
    tick_n = 0; last_act = -1; fa_l = 0; fa_r = 0; px_l = 0; px_r = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ":f_l"}, 32'(fl), 32'((fa_l / 8) * 64));
    chk({tag, ":f_r"}, 32'(fr), 32'((fa_r / 8) * 64));
    chk({tag, ":p_l"}, 32'(pl), 32'(px_l * 64));
    chk({tag, ":p_r"}, 32'(pr), 32'(px_r * 64));
    chk({tag, ":f_mode"}, 32'(fm), 32'(mode_now()));
    chk({tag, ":p_mode"}, 32'(pm), 32'(mode_now()));
  endtask

  task automatic step();
    int xl, xr;
    bit pre;
    pre = mode_now();
    xl = pre ? 2 * int'(ch_a) + int'(ch_b) + 32 * int'(spk) : 128 * int'(spk);
    xr = pre ? 2 * int'(ch_c) + int'(ch_b) + 32 * int'(spk) : 128 * int'(spk);
    ce = 1'b1;
    @(posedge clk_sys);
    #1 ce = 1'b0;
    fa_l = fa_l + xl - fa_l / 8;
    fa_r = fa_r + xr - fa_r / 8;
    px_l = xl;
    px_r = xr;
    if (psg_active != 6'd0) last_act = tick_n;
    tick_n++;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  initial begin
    idle(2);
    chk_all("reset");
    @(negedge clk_sys) reset = 1'b0;
    idle(1);
    chk_all("post_release");
    // step response
    ch_a = 8'd200; psg_active = 6'd1;
    step(); chk_all("step1");
    chk("step1_audio_l", 32'(fl), 32'd0);
    chk("step1_mode", 32'(fm), 32'd1);
    step(); chk_all("step2");
    chk("step2_audio_l", 32'(fl), 32'h0C80);
    step(); chk_all("step3");
    chk("step3_audio_l", 32'(fl), 32'(93 * 64));
    // channel split, still in PSG mode via hold
    psg_active = 6'd0; ch_a = 8'd255; ch_b = 8'd255; ch_c = 8'd0; spk = 3'd7;
    step(); chk_all("split");
    chk("split_l", 32'(pl), 32'(989 * 64));
    chk("split_r", 32'(pr), 32'(479 * 64));
    // let the hold expire, then single pulse
    for (int i = 0; i < 18; i++) begin step(); chk_all("drain"); end
    chk("drained_mode", 32'(pm), 32'd0);
    spk = 3'd7; ch_a = 8'd0; ch_b = 8'd0; ch_c = 8'd0;
    step(); chk_all("spk_only");
    chk("spk_only_l", 32'(pl), 32'hE000);
    chk("spk_only_r", 32'(pr), 32'hE000);
    psg_active = 6'd4;
    step(); chk_all("pulse");
    psg_active = 6'd0;
    for (int i = 1; i <= 17; i++) begin
      ch_a = 8'($urandom); ch_b = 8'($urandom); ch_c = 8'($urandom);
      step(); chk_all("hold");
      chk("hold_mode_tick", 32'(pm), 32'(i < 16));
    end
    // pulse, then a second pulse at tick 10 extends the hold
    psg_active = 6'd1; step(); chk_all("ext_p1");
    psg_active = 6'd0;
    for (int i = 1; i < 10; i++) begin step(); chk_all("ext_a"); end
    psg_active = 6'h20; step(); chk_all("ext_p2");
    psg_active = 6'd0;
    for (int i = 1; i <= 17; i++) begin
      step(); chk_all("ext_b");
      chk("ext_mode_tick", 32'(pm), 32'(i < 16));
    end
    // randomized traffic with occasional idle gaps
    for (int i = 0; i < 300; i++) begin
      ch_a = 8'($urandom); ch_b = 8'($urandom); ch_c = 8'($urandom); spk = 3'($urandom);
      psg_active = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      step(); chk_all("rnd");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    // ce gating: inputs toggle but nothing moves
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_sys);
      #1;
      ch_a = 8'($urandom); ch_b = 8'($urandom); ch_c = 8'($urandom); spk = 3'($urandom);
      psg_active = 6'($urandom);
    end
    chk_all("gate");
    // async reset mid-ramp
    psg_active = 6'd0; spk = 3'd5;
    step(); step(); step();
    chk_all("ramp");
    chk("ramp_nonzero", 32'(fl != 16'd0), 32'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    ce = 1'b1;
    @(posedge clk_sys);
    #1 ce = 1'b0;
    chk_all("rst_with_ce");
    @(negedge clk_sys) reset = 1'b0;
    idle(3);
    chk_all("rst_released");
    step(); chk_all("first_after_rst");
    step(); chk_all("second_after_rst");
    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end
endmodule
